num15_turn_ctrl: RTL and testbench

NUM15_TURN_CTRL -- requirements
Module: num15_turn_ctrl

---
 rtl/num15_pkg.sv | 10 +
 rtl/num15_win_detect.sv | 13 +
 rtl/num15_turn_ctrl.sv | 108 ++++++++++
 tb/tb_num15_turn_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/num15_pkg.sv
// num15_pkg: shared FSM states, move type and winning-line masks for the number-15 game
package num15_pkg;
  typedef enum logic [2:0] {COMP_REQ, COMP_WAIT, H_WAIT, H_CHECK, H_RELEASE, DONE} state_t;
  typedef logic [3:0] move_t;
  localparam logic [8:0] WIN_LINES [8] = '{9'h062, 9'h111, 9'h08C, 9'h10A, 9'h054, 9'h0A1, 9'h092, 9'h038};
  localparam logic [8:0] ALL_TAKEN = 9'h1FF;
  function automatic logic [8:0] move_mask(input move_t m);
    return (m >= 4'd1 && m <= 4'd9) ? 9'd1 << (m - 4'd1) : 9'd0;
  endfunction
endpackage

// File: rtl/num15_win_detect.sv
// num15_win_detect: flags a set of taken numbers that contains any three summing to 15
module num15_win_detect
  import num15_pkg::*;
(
  input  logic [8:0] taken,
  output logic       win
);
  // any winning line fully covered by the set
  always_comb begin
    win = 1'b0;
    for (int i = 0; i < 8; i++) win = win | ((taken & WIN_LINES[i]) == WIN_LINES[i]);
  end
endmodule

// File: rtl/num15_turn_ctrl.sv
// num15_turn_ctrl: turn sequencing between the move engine and a human player for the number-15 game
module num15_turn_ctrl
  import num15_pkg::*;
(
  input  logic       clock,
  input  logic       reset_L,
  input  logic       enter_L,
  input  logic       newGame_L,
  input  logic [3:0] hMove,
  output logic       compReq,
  input  logic [3:0] compMove,
  input  logic       compValid,
  output logic [8:0] hSet,
  output logic [8:0] cSet,
  output logic [3:0] cMove,
  output logic [3:0] lastH,
  output logic       win,
  output logic       hWin,
  output logic       draw,
  output logic       illegal,
  output logic       engErr
);
  state_t     state, nxt;
  move_t      hreg;
  logic [8:0] cmask, hmask, c_next;
  logic       c_ok, h_ok, c_win, h_win, c_full, h_full;

  assign cmask  = move_mask(compMove);
  assign hmask  = move_mask(hreg);
  assign c_ok   = (cmask != 9'd0) && ((cmask & (hSet | cSet)) == 9'd0);
  assign h_ok   = (hmask != 9'd0) && ((hmask & (hSet | cSet)) == 9'd0);
  assign c_next = cSet | cmask;
  assign c_full = (c_next | hSet) == ALL_TAKEN;
  assign h_full = (hSet | cSet) == ALL_TAKEN;

  // the engine's candidate move is judged together with the set it would join
  num15_win_detect u_cwin (.taken(c_next), .win(c_win));
  num15_win_detect u_hwin (.taken(hSet), .win(h_win));

  // next-state routing; a new-game request overrides every other transition
  always_comb begin
    nxt = state;
    case (state)
      COMP_REQ:  nxt = COMP_WAIT;
      COMP_WAIT: nxt = !compValid ? COMP_WAIT : (!c_ok || c_win || c_full) ? DONE : H_WAIT;
      H_WAIT:    nxt = enter_L ? H_WAIT : H_CHECK;
      H_CHECK:   nxt = H_RELEASE;
      H_RELEASE: nxt = !enter_L ? H_RELEASE : illegal ? H_WAIT : (h_win || h_full) ? DONE : COMP_REQ;
      default:   nxt = state;
    endcase
    if (!newGame_L) nxt = COMP_REQ;
  end

  // state, registered request line and game record
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state   <= COMP_REQ;
      compReq <= 1'b0;
      hreg    <= '0;
      hSet    <= '0;
      cSet    <= '0;
      cMove   <= '0;
      lastH   <= '0;
      win     <= 1'b0;
      hWin    <= 1'b0;
      draw    <= 1'b0;
      illegal <= 1'b0;
      engErr  <= 1'b0;
    end else begin
      state   <= nxt;
      compReq <= (nxt == COMP_REQ) || (nxt == COMP_WAIT);
      if (!newGame_L) begin
        hreg    <= '0;
        hSet    <= '0;
        cSet    <= '0;
        cMove   <= '0;
        lastH   <= '0;
        win     <= 1'b0;
        hWin    <= 1'b0;
        draw    <= 1'b0;
        illegal <= 1'b0;
        engErr  <= 1'b0;
      end else begin
        case (state)
          COMP_WAIT: if (compValid) begin
            if (c_ok) begin
              cSet  <= c_next;
              cMove <= compMove;
              win   <= c_win;
              draw  <= !c_win && c_full;
            end else engErr <= 1'b1;
          end
          H_WAIT:    if (!enter_L) hreg <= hMove;
          H_CHECK:   if (h_ok) begin
            hSet    <= hSet | hmask;
            lastH   <= hreg;
            illegal <= 1'b0;
          end else illegal <= 1'b1;
          H_RELEASE: if (enter_L && !illegal) begin
            hWin <= h_win;
            draw <= !h_win && h_full;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_num15_turn_ctrl.sv
// tb_num15_turn_ctrl: scoreboard bench with a game-level reference model for num15_turn_ctrl
module tb_num15_turn_ctrl;
  logic clock = 1'b0, reset_L = 1'b0, enter_L = 1'b1, newGame_L = 1'b1, compValid = 1'b0;
  logic [3:0] hMove = '0, compMove = '0;
  logic compReq, win, hWin, draw, illegal, engErr;
  logic [8:0] hSet, cSet;
  logic [3:0] cMove, lastH;

  num15_turn_ctrl dut (
    .clock(clock), .reset_L(reset_L), .enter_L(enter_L), .newGame_L(newGame_L),
    .hMove(hMove), .compReq(compReq), .compMove(compMove), .compValid(compValid),
    .hSet(hSet), .cSet(cSet), .cMove(cMove), .lastH(lastH),
    .win(win), .hWin(hWin), .draw(draw), .illegal(illegal), .engErr(engErr)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] prev;
  logic [8:0] m_h = '0, m_c = '0;
  logic [3:0] m_cm = '0, m_lh = '0;
  logic m_win = 0, m_hwin = 0, m_draw = 0, m_ill = 0, m_err = 0, m_req = 0;
  wire [31:0] dut_snap = {compReq, hSet, cSet, cMove, lastH, win, hWin, draw, illegal, engErr};

  function automatic logic [31:0] snap();
    return {m_req, m_h, m_c, m_cm, m_lh, m_win, m_hwin, m_draw, m_ill, m_err};
  endfunction

  function automatic bit has_line(logic [8:0] s);
    for (int a = 1; a <= 7; a++)
      for (int b = a + 1; b <= 8; b++) begin
        int c;
        c = 15 - a - b;
        if (c > b && c <= 9 && s[a-1] && s[b-1] && s[c-1]) return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic bit legal(int m);
    logic [8:0] t;
    t = m_h | m_c;
    return m >= 1 && m <= 9 && !t[m-1];
  endfunction

  function automatic int pick_free();
    int n;
    do n = int'($urandom_range(1, 9)); while (!legal(n));
    return n;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    m_h = '0; m_c = '0; m_cm = '0; m_lh = '0;
    m_win = 0; m_hwin = 0; m_draw = 0; m_ill = 0; m_err = 0; m_req = 0;
  endtask

  always @(negedge clock) begin
    if (!reset_L) prev = dut_snap;
    else if (dut_snap !== prev) begin
      prev = dut_snap;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_change: got %h expected no change", dut_snap);
      end else check("monitor", dut_snap, exp_q.pop_front());
    end
  end

  task automatic settle(string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s: %0d expected events pending, got none", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clock);
    check(name, dut_snap, snap());
  endtask

  task automatic eng_move(int mv);
    int n;
    n = 0;
    while (!compReq && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!compReq) begin
      checks++;
      failures++;
      $display("FAIL eng_req_timeout: got compReq=0 expected 1");
      return;
    end
    @(posedge clock);
    repeat ($urandom_range(0, 2)) @(posedge clock);
    #1 compValid = 1'b1;
    compMove = 4'(mv);
    if (legal(mv)) begin
      m_c[mv-1] = 1'b1;
      m_cm = 4'(mv);
      if (has_line(m_c)) m_win = 1;
      else if ((m_h | m_c) == 9'h1FF) m_draw = 1;
    end else m_err = 1;
    m_req = 0;
    exp_q.push_back(snap());
    @(posedge clock);
    #1 compValid = 1'b0;
    compMove = 4'($urandom_range(0, 15));
  endtask

  task automatic hum_move(int mv, int hold);
    @(posedge clock);
    #1 enter_L = 1'b0;
    hMove = 4'(mv);
    if (legal(mv)) begin
      m_h[mv-1] = 1'b1;
      m_lh = 4'(mv);
      m_ill = 0;
      exp_q.push_back(snap());
    end else if (!m_ill) begin
      m_ill = 1;
      exp_q.push_back(snap());
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clock);
      #1 hMove = 4'($urandom_range(0, 15));
      if (hold > 1) check("hold_no_req", {31'b0, compReq}, 32'h0);
    end
    enter_L = 1'b1;
    if (!m_ill) begin
      if (has_line(m_h)) m_hwin = 1;
      else if ((m_h | m_c) == 9'h1FF) m_draw = 1;
      else m_req = 1;
      exp_q.push_back(snap());
    end
  endtask

  task automatic new_game();
    logic [31:0] old;
    @(posedge clock);
    #1 newGame_L = 1'b0;
    old = snap();
    clear_model();
    m_req = 1;
    if (snap() !== old) exp_q.push_back(snap());
    @(posedge clock);
    #1 newGame_L = 1'b1;
    settle("new_game");
  endtask

  task automatic poke_done();
    @(posedge clock);
    #1 enter_L = 1'b0;
    compValid = 1'b1;
    compMove = 4'(pick_free());
    hMove = 4'(pick_free());
    repeat (2) @(posedge clock);
    #1 enter_L = 1'b1;
    compValid = 1'b0;
    repeat (3) @(posedge clock);
    settle("done_hold");
  endtask

  task automatic play(input int seq[], input string name);
    foreach (seq[i]) begin
      if (i % 2 == 0) eng_move(seq[i]); else hum_move(seq[i], 1);
      settle(name);
    end
  endtask

  task automatic random_game();
    int guard;
    guard = 0;
    while (!(m_win || m_hwin || m_draw || m_err) && guard < 40) begin
      guard++;
      eng_move(($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : pick_free());
      settle("rand_eng");
      if (m_win || m_draw || m_err) break;
      do begin
        hum_move(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : pick_free(), int'($urandom_range(1, 3)));
        settle("rand_hum");
        guard++;
      end while (m_ill && guard < 40);
    end
    new_game();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #12 check("reset", dut_snap, snap());
    @(posedge clock);
    #1 reset_L = 1'b1;
    m_req = 1;
    exp_q.push_back(snap());
    settle("reset_release");

    play('{5, 6, 1, 9, 3, 2, 7}, "game_cwin");
    check("cwin_cset", {23'b0, cSet}, 32'h55);
    check("cwin_hset", {23'b0, hSet}, 32'h122);
    check("cwin_flag", {31'b0, win}, 32'h1);
    poke_done();
    new_game();

    eng_move(5);
    settle("ill_eng");
    hum_move(5, 1);
    settle("ill_taken");
    check("ill_flag", {31'b0, illegal}, 32'h1);
    hum_move(0, 1);
    settle("ill_zero");
    hum_move(6, 2);
    settle("ill_recover");
    new_game();

    eng_move(5);
    settle("hold_eng");
    hum_move(6, 5);
    settle("hold_hum");
    check("hold_hset", {23'b0, hSet}, 32'h20);
    new_game();

    play('{5, 1, 5}, "eng_err");
    check("err_cset", {23'b0, cSet}, 32'h10);
    check("err_flag", {31'b0, engErr}, 32'h1);
    new_game();

    play('{5, 1, 9, 2, 3, 7, 4, 6}, "game_hwin");
    check("hwin_flag", {31'b0, hWin}, 32'h1);
    new_game();

    play('{2, 7, 6, 5, 9, 1, 3, 4, 8}, "game_draw");
    check("draw_full", {23'b0, hSet | cSet}, 32'h1FF);
    check("draw_flags", {29'b0, draw, win, hWin}, 32'h4);
    new_game();

    eng_move(5);
    settle("ng_eng");
    hum_move(pick_free(), 1);
    settle("ng_hum");
    while (!compReq) @(negedge clock);
    @(posedge clock);
    #1 compValid = 1'b1;
    compMove = 4'(pick_free());
    newGame_L = 1'b0;
    clear_model();
    m_req = 1;
    exp_q.push_back(snap());
    @(posedge clock);
    #1 compValid = 1'b0;
    newGame_L = 1'b1;
    settle("ng_discard");

    eng_move(pick_free());
    settle("rst_eng");
    @(posedge clock);
    #1 enter_L = 1'b0;
    hMove = 4'(pick_free());
    @(posedge clock);
    #2 reset_L = 1'b0;
    clear_model();
    #1 check("rst_hcheck", dut_snap, snap());
    @(posedge clock);
    #1 reset_L = 1'b1;
    enter_L = 1'b1;
    m_req = 1;
    exp_q.push_back(snap());
    settle("rst_release");

    repeat (6) random_game();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
